// File: rtl/pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_unit : semiMIPS fetch program counter with branch/jump/call/return      |
// |           support backed by a circular return-address stack.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_unit #(
  parameter int DATAWIDTH  = 32,
  parameter int UPPERLIMIT = 4096,
  parameter int STEP       = 4,
  parameter int RESET_ADDR = 0,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [DATAWIDTH-1:0]         br_off,
  input  logic [25:0]                  j_tgt,
  input  logic [DATAWIDTH-1:0]         r_tgt,
  output logic [DATAWIDTH-1:0]         pc,
  output logic [DATAWIDTH-1:0]         pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
  output logic                         f_align,
  output logic                         f_range,
  output logic                         f_ovf,
  output logic                         f_unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [DATAWIDTH-1:0] C_UPPER = DATAWIDTH'(UPPERLIMIT);
  localparam logic [DATAWIDTH-1:0] C_STEP  = DATAWIDTH'(STEP);
  localparam logic [DATAWIDTH-1:0] C_RESET = DATAWIDTH'(RESET_ADDR);
  localparam logic [CW-1:0]        C_DEPTH = CW'(RAS_DEPTH);
  localparam logic [CW-1:0]        C_CONE  = CW'(1);
  localparam logic [PW-1:0]        C_LAST  = PW'(RAS_DEPTH - 1);
  localparam logic [PW-1:0]        C_PONE  = PW'(1);

  localparam logic [2:0] M_BR   = 3'd1;
  localparam logic [2:0] M_J    = 3'd2;
  localparam logic [2:0] M_JR   = 3'd3;
  localparam logic [2:0] M_CALL = 3'd4;
  localparam logic [2:0] M_RET  = 3'd5;

  logic [DATAWIDTH-1:0] pc_q;
  logic [DATAWIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]        top_q, top_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 fa_q, fr_q, fo_q, fu_q;

  logic [DATAWIDTH-1:0] w_seq, w_jtgt, w_cand, w_pc_next;
  logic [PW-1:0]        w_top_inc, w_top_dec;
  logic                 w_checked, w_is_call, w_is_ret, w_empty, w_full;
  logic                 w_bad_align, w_bad_range, w_unf, w_accept;
  logic                 w_push, w_pop, w_ovf;

  assign w_seq = (pc_q >= C_UPPER) ? C_RESET : pc_q + C_STEP;

  // Jump targets keep the region bits of the sequential address above bit 27.
  if (DATAWIDTH > 28) begin : g_jt_region
    assign w_jtgt = {w_seq[DATAWIDTH-1:28], j_tgt, 2'b00};
  end else begin : g_jt_flat
    assign w_jtgt = {j_tgt, 2'b00};
  end

  assign w_empty   = (cnt_q == '0);
  assign w_full    = (cnt_q == C_DEPTH);
  assign w_top_inc = (top_q == C_LAST) ? '0 : top_q + C_PONE;
  assign w_top_dec = (top_q == '0) ? C_LAST : top_q - C_PONE;

  always_comb begin
    w_cand    = w_seq;
    w_checked = 1'b0;
    w_is_call = 1'b0;
    w_is_ret  = 1'b0;
    case (mode)
      M_BR: begin
        w_cand    = w_seq + (br_off << 2);
        w_checked = 1'b1;
      end
      M_J: begin
        w_cand    = w_jtgt;
        w_checked = 1'b1;
      end
      M_JR: begin
        w_cand    = r_tgt;
        w_checked = 1'b1;
      end
      M_CALL: begin
        w_cand    = w_jtgt;
        w_checked = 1'b1;
        w_is_call = 1'b1;
      end
      M_RET: begin
        w_cand    = ras_q[top_q];
        w_checked = ~w_empty;
        w_is_ret  = 1'b1;
      end
      default: ;
    endcase
  end

  // Misalignment takes precedence over the range fault.
  assign w_bad_align = w_checked && (w_cand[1:0] != 2'b00);
  assign w_bad_range = w_checked && !w_bad_align && (w_cand > C_UPPER);
  assign w_unf       = w_is_ret && w_empty;
  assign w_accept    = !w_bad_align && !w_bad_range && !w_unf;
  assign w_pc_next   = w_accept ? w_cand : pc_q;

  // A faulting return address is still consumed from the stack.
  assign w_push = w_is_call && w_accept;
  assign w_pop  = w_is_ret && !w_empty;
  assign w_ovf  = w_push && w_full;

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (w_push) begin
      top_d = w_top_inc;
      cnt_d = w_full ? cnt_q : cnt_q + C_CONE;
    end else if (w_pop) begin
      top_d = w_top_dec;
      cnt_d = cnt_q - C_CONE;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q  <= C_RESET;
      top_q <= '0;
      cnt_q <= '0;
      fa_q  <= 1'b0;
      fr_q  <= 1'b0;
      fo_q  <= 1'b0;
      fu_q  <= 1'b0;
    end else if (en) begin
      pc_q  <= w_pc_next;
      top_q <= top_d;
      cnt_q <= cnt_d;
      fa_q  <= w_bad_align;
      fr_q  <= w_bad_range;
      fo_q  <= w_ovf;
      fu_q  <= w_unf;
    end else begin
      fa_q  <= 1'b0;
      fr_q  <= 1'b0;
      fo_q  <= 1'b0;
      fu_q  <= 1'b0;
    end
  end

  // Stack contents need no reset: the cleared count marks every entry invalid.
  always_ff @(posedge clk) begin
    if (en && w_push) ras_q[w_top_inc] <= w_seq;
  end

  assign pc      = pc_q;
  assign pc_next = w_pc_next;
  assign ras_cnt = cnt_q;
  assign f_align = fa_q;
  assign f_range = fr_q;
  assign f_ovf   = fo_q;
  assign f_unf   = fu_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_unit : self-checking bench for pc_unit, directed scenarios plus a    |
// |              randomized run against a queue-based reference model.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        clr, en;
  logic [2:0]  mode;
  logic [31:0] br_off, r_tgt;
  logic [25:0] j_tgt;
  logic [31:0] pc, pc_next;
  logic [2:0]  ras_cnt;
  logic        f_align, f_range, f_ovf, f_unf;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_fa, m_fr, m_fo, m_fu;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .br_off(br_off), .j_tgt(j_tgt),
    .r_tgt(r_tgt), .pc(pc), .pc_next(pc_next), .ras_cnt(ras_cnt),
    .f_align(f_align), .f_range(f_range), .f_ovf(f_ovf), .f_unf(f_unf)
  );

  function automatic logic [31:0] m_seq();
    return (m_pc >= 32'd4096) ? 32'd0 : m_pc + 32'd4;
  endfunction

  // Reference: target and fault classification for the currently driven mode.
  function automatic void m_eval(output logic [31:0] tgt, output bit ok,
                                 output bit fa, output bit fr, output bit fu);
    logic [31:0] seq;
    seq = m_seq();
    tgt = seq; fa = 0; fr = 0; fu = 0;
    case (int'(mode))
      1: tgt = seq + br_off * 32'd4;
      2, 4: tgt = (seq & 32'hF000_0000) | (32'(j_tgt) * 32'd4);
      3: tgt = r_tgt;
      5: if (m_ras.size() == 0) fu = 1; else tgt = m_ras[$];
      default: ;
    endcase
    if (int'(mode) >= 1 && int'(mode) <= 5 && !fu) begin
      if (tgt % 4 != 0) fa = 1;
      else if (tgt > 32'd4096) fr = 1;
    end
    ok = !(fa || fr || fu);
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] t; bit ok, a, r, u;
    m_eval(t, ok, a, r, u);
    return ok ? t : m_pc;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ras.delete(); m_fa = 0; m_fr = 0; m_fo = 0; m_fu = 0;
  endtask

  task automatic model_edge();
    logic [31:0] t, seq; bit ok, a, r, u;
    if (!en) begin
      m_fa = 0; m_fr = 0; m_fo = 0; m_fu = 0;
      return;
    end
    seq = m_seq();
    m_eval(t, ok, a, r, u);
    m_fo = 0;
    if (int'(mode) == 4 && ok) begin
      m_ras.push_back(seq);
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front());
        m_fo = 1;
      end
    end
    if (int'(mode) == 5 && !u) void'(m_ras.pop_back());
    m_fa = a; m_fr = r; m_fu = u;
    if (ok) m_pc = t;
  endtask

  task automatic drive(input int m, input logic [31:0] b, input logic [25:0] j,
                       input logic [31:0] r, input logic e);
    mode = 3'(m); br_off = b; j_tgt = j; r_tgt = r; en = e;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    model_reset();
    #12;
    vectors++;
    if (pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", pc); end
    vectors++;
    if (ras_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", ras_cnt); end
    vectors++;
    if ({f_align, f_range, f_ovf, f_unf} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {f_align, f_range, f_ovf, f_unf});
    end
    @(negedge clk);
    clr = 1'b1;
    cycle();
  endtask

  task automatic test_seq_wrap();
    drive(0, 0, 0, 0, 1'b1);
    for (int k = 1; k <= 1030; k++) begin
      #1;
      vectors++;
      if (pc_next !== m_next()) begin
        miscompares++; $display("FAIL seq_pc_next: step %0d got %h want %h", k, pc_next, m_next());
      end
      cycle();
      vectors++;
      if (pc !== m_pc) begin miscompares++; $display("FAIL seq_pc: step %0d got %h want %h", k, pc, m_pc); end
      if (k == 1024) begin
        vectors++;
        if (pc !== 32'd4096) begin miscompares++; $display("FAIL seq_top: got %h want 1000", pc); end
      end
      if (k == 1025) begin
        vectors++;
        if (pc !== 32'd0) begin miscompares++; $display("FAIL seq_wrap: got %h want 0", pc); end
      end
    end
  endtask

  task automatic test_branch();
    drive(3, 0, 0, 32'h100, 1'b1);
    cycle();
    drive(1, 32'hFFFF_FFFE, 0, 0, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'hFC) begin miscompares++; $display("FAIL br_back: got %h want fc", pc); end
    drive(1, 32'h7FF, 0, 0, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'hFC || f_range !== 1'b1 || f_align !== 1'b0) begin
      miscompares++; $display("FAIL br_range: got pc=%h fr=%b fa=%b want fc 1 0", pc, f_range, f_align);
    end
    drive(0, 0, 0, 0, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'h100 || f_range !== 1'b0) begin
      miscompares++; $display("FAIL br_pulse: got pc=%h fr=%b want 100 0", pc, f_range);
    end
  endtask

  task automatic test_jr_align();
    drive(3, 0, 0, 32'h202, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'h100 || f_align !== 1'b1) begin
      miscompares++; $display("FAIL jr_misalign: got pc=%h fa=%b want 100 1", pc, f_align);
    end
    drive(3, 0, 0, 32'h200, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'h200 || f_align !== 1'b0) begin
      miscompares++; $display("FAIL jr_ok: got pc=%h fa=%b want 200 0", pc, f_align);
    end
    drive(3, 0, 0, 32'h2002, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'h200 || f_align !== 1'b1 || f_range !== 1'b0) begin
      miscompares++; $display("FAIL jr_both: got pc=%h fa=%b fr=%b want 200 1 0", pc, f_align, f_range);
    end
    drive(3, 0, 0, 32'd4096, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'd4096 || f_range !== 1'b0) begin
      miscompares++; $display("FAIL jr_limit: got pc=%h fr=%b want 1000 0", pc, f_range);
    end
    drive(3, 0, 0, 32'd4100, 1'b1);
    cycle();
    vectors++;
    if (pc !== 32'd4096 || f_range !== 1'b1) begin
      miscompares++; $display("FAIL jr_over: got pc=%h fr=%b want 1000 1", pc, f_range);
    end
  endtask

  task automatic test_call_ret();
    logic [31:0] rets [4];
    rets[0] = 32'h104; rets[1] = 32'hC4; rets[2] = 32'h84; rets[3] = 32'h44;
    drive(3, 0, 0, 32'h40, 1'b1);
    cycle();
    for (int k = 1; k <= 5; k++) begin
      drive(4, 0, 26'(k * 16), 0, 1'b1);
      cycle();
      vectors++;
      if (pc !== 32'(k * 64) || ras_cnt !== 3'((k > 4) ? 4 : k) || f_ovf !== (k == 5)) begin
        miscompares++;
        $display("FAIL call_%0d: got pc=%h cnt=%0d ovf=%b want %h %0d %b",
                 k, pc, ras_cnt, f_ovf, k * 64, (k > 4) ? 4 : k, k == 5);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(5, 0, 0, 0, 1'b1);
      cycle();
      vectors++;
      if (pc !== rets[k] || ras_cnt !== 3'(3 - k) || f_ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL ret_%0d: got pc=%h cnt=%0d want %h %0d", k, pc, ras_cnt, rets[k], 3 - k);
      end
    end
    cycle();
    vectors++;
    if (pc !== 32'h44 || f_unf !== 1'b1 || ras_cnt !== 3'd0) begin
      miscompares++; $display("FAIL ret_empty: got pc=%h unf=%b cnt=%0d want 44 1 0", pc, f_unf, ras_cnt);
    end
  endtask

  task automatic test_en_hold_reset();
    drive(4, 0, 26'h80, 0, 1'b1);
    cycle();
    drive(4, 0, 26'h100, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      vectors++;
      if (pc !== m_pc || ras_cnt !== 3'(m_ras.size()) ||
          {f_align, f_range, f_ovf, f_unf} !== 4'b0) begin
        miscompares++;
        $display("FAIL en_hold: got pc=%h cnt=%0d fl=%b want %h %0d 0000",
                 pc, ras_cnt, {f_align, f_range, f_ovf, f_unf}, m_pc, m_ras.size());
      end
    end
    en = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    vectors++;
    if (pc !== 32'd0 || ras_cnt !== 3'd0) begin
      miscompares++; $display("FAIL clr_async: got pc=%h cnt=%0d want 0 0", pc, ras_cnt);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (pc !== 32'd0 || ras_cnt !== 3'd0 || f_ovf !== 1'b0) begin
      miscompares++; $display("FAIL clr_edge: got pc=%h cnt=%0d ovf=%b want 0 0 0", pc, ras_cnt, f_ovf);
    end
    model_reset();
    @(negedge clk);
    clr = 1'b1;
    en = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] exp_next;
    for (int k = 0; k < 400; k++) begin
      drive(int'($urandom_range(0, 7)), 32'($urandom_range(0, 800)) - 32'd400,
            26'($urandom_range(0, 1100)), 32'($urandom_range(0, 4200)),
            ($urandom_range(0, 9) != 0));
      #1;
      exp_next = m_next();
      vectors++;
      if (pc_next !== exp_next) begin
        miscompares++; $display("FAIL rnd_pc_next: iter %0d got %h want %h", k, pc_next, exp_next);
      end
      cycle();
      vectors++;
      if (pc !== m_pc || ras_cnt !== 3'(m_ras.size())) begin
        miscompares++;
        $display("FAIL rnd_state: iter %0d got pc=%h cnt=%0d want %h %0d", k, pc, ras_cnt, m_pc, m_ras.size());
      end
      vectors++;
      if ({f_align, f_range, f_ovf, f_unf} !== {m_fa, m_fr, m_fo, m_fu}) begin
        miscompares++;
        $display("FAIL rnd_flags: iter %0d got %b want %b", k,
                 {f_align, f_range, f_ovf, f_unf}, {m_fa, m_fr, m_fo, m_fu});
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_branch();
    test_jr_align();
    test_call_ret();
    test_en_hold_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
